// File: rtl/btnreq_master_if.sv
// Wishbone master/slave signal bundle between btnreq_master and the LED walker slave.
interface btnreq_master_if;
    logic        o_cyc;
    logic        o_stb;
    logic        o_we;
    logic        o_addr;
    logic [31:0] o_data;
    logic        i_stall;
    logic        i_ack;
    logic [31:0] i_data;

    modport master (
        output o_cyc, o_stb, o_we, o_addr, o_data,
        input  i_stall, i_ack, i_data
    );

    modport slave (
        input  o_cyc, o_stb, o_we, o_addr, o_data,
        output i_stall, i_ack, i_data
    );
endinterface

// File: rtl/btnreq_master.sv
// Button-driven Wishbone master: one debounced press issues a walk write to the LED walker,
// then polls its status until idle, counting completed walks and flagging bus timeouts.
module btnreq_master #(
    parameter int DEBOUNCE = 500_000,
    parameter int POLL_GAP = 1024,
    parameter int TIMEOUT  = 64
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_btn,
    btnreq_master_if.master bus,
    output logic            o_busy,
    output logic [15:0]     o_count,
    output logic            o_err
);
    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int GP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int TO_W = (TIMEOUT  > 1) ? $clog2(TIMEOUT)  : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [GP_W-1:0] GP_LAST = GP_W'(POLL_GAP - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WACK, S_GAP, S_RD, S_RACK} state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic            db_q, db_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_q, press_d;
    logic [GP_W-1:0] gap_q, gap_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [15:0]     count_q, count_d;
    logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, busy_q, busy_d, err_q, err_d;
    logic            unused_data;

    assign unused_data = ^bus.i_data[31:4];

    // Debounce: count while the synchronised level disagrees with the accepted one.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        press_d  = 1'b0;
        if (sync2_q != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d    = sync2_q;
                press_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        to_d    = to_q;
        count_d = count_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (press_q) begin
                    state_d = S_WR;
                    to_d    = '0;
                end
            end
            S_WR, S_RD: begin
                to_d = to_q + TO_W'(1);
                if (to_q == TO_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (!bus.i_stall) begin
                    state_d = (state_q == S_WR) ? S_WACK : S_RACK;
                end
            end
            S_WACK, S_RACK: begin
                to_d = to_q + TO_W'(1);
                // A terminal-count ack still completes the transfer.
                if (bus.i_ack) begin
                    if (state_q == S_RACK && bus.i_data[3:0] == 4'h0) begin
                        state_d = S_IDLE;
                        count_d = count_q + 16'd1;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GP_LAST) begin
                    state_d = S_RD;
                    to_d    = '0;
                end else begin
                    gap_d = gap_q + GP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        cyc_d  = state_d inside {S_WR, S_WACK, S_RD, S_RACK};
        stb_d  = state_d inside {S_WR, S_RD};
        we_d   = (state_d == S_WR);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_q     <= 1'b0;
            db_cnt_q <= '0;
            press_q  <= 1'b0;
            gap_q    <= '0;
            to_q     <= '0;
            count_q  <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= i_btn;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
            press_q  <= press_d;
            gap_q    <= gap_d;
            to_q     <= to_d;
            count_q  <= count_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign bus.o_cyc  = cyc_q;
    assign bus.o_stb  = stb_q;
    assign bus.o_we   = we_q;
    assign bus.o_addr = 1'b0;
    assign bus.o_data = 32'h0000_0001;
    assign o_busy     = busy_q;
    assign o_count    = count_q;
    assign o_err      = err_q;
endmodule
